// File: rtl/timer_dev_pkg.sv
// Shared constants for the memory-mapped down-counter timer: register map,
// CTRL bit positions, mode codes and FSM state encoding.
package timer_dev_pkg;

  localparam int WORD_W = 32;
  localparam int ADDR_W = 30;

  localparam logic [1:0] OFF_CTRL   = 2'd0;
  localparam logic [1:0] OFF_PRESET = 2'd1;
  localparam logic [1:0] OFF_COUNT  = 2'd2;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_MODE_LO = 1;
  localparam int CTRL_MODE_HI = 2;
  localparam int CTRL_IM      = 3;

  localparam logic [1:0] MODE_ONESHOT = 2'd0;
  localparam logic [1:0] MODE_RELOAD  = 2'd1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CNT  = 2'd2,
    INT  = 2'd3
  } state_t;

endpackage

// File: rtl/timer_dev_if.sv
// Bridge-side bus of the timer: word address, write strobe/data, read data
// and the interrupt line towards CP0.
interface timer_dev_if;
  import timer_dev_pkg::*;

  logic [ADDR_W-1:0] addr;
  logic              we;
  logic [WORD_W-1:0] wd;
  logic [WORD_W-1:0] rd;
  logic              irq;

  modport master (output addr, we, wd, input rd, irq);
  modport slave  (input addr, we, wd, output rd, irq);

endinterface

// File: rtl/timer_dev.sv
// Programmable 32-bit down-counter timer with one-shot / auto-reload modes
// and a maskable interrupt, programmed through a 4-word register window.
//
//   state | meaning
//   ------+-------------------------------------------------
//   IDLE  | waiting for CTRL.En
//   LOAD  | COUNT <= PRESET
//   CNT   | decrementing; expiry when COUNT is 0 or 1
//   INT   | expiry handling: one-shot clears En, reload drops irq flag
module timer_dev
  import timer_dev_pkg::*;
(
  input logic        clk,
  input logic        reset,
  timer_dev_if.slave bus
);

  logic              en;
  logic [1:0]        mode;
  logic              im;
  logic [WORD_W-1:0] preset;
  logic [WORD_W-1:0] count;
  logic              irqFlag;
  state_t            state;

  logic [1:0]        offset;
  logic              ctrlWe;
  logic              presetWe;
  logic [WORD_W-1:0] rdMux;
  logic              unusedAddr;

  assign offset     = bus.addr[1:0];
  assign ctrlWe     = bus.we && (offset == OFF_CTRL);
  assign presetWe   = bus.we && (offset == OFF_PRESET);
  assign unusedAddr = ^bus.addr[ADDR_W-1:2];

  always_ff @(posedge clk) begin
    if (reset) begin
      en      <= 1'b0;
      mode    <= MODE_ONESHOT;
      im      <= 1'b0;
      preset  <= '0;
      count   <= '0;
      irqFlag <= 1'b0;
      state   <= IDLE;
    end else begin
      if (presetWe) preset <= bus.wd;

      case (state)
        IDLE: if (en) state <= LOAD;
        LOAD: begin
          count <= preset;
          state <= CNT;
        end
        CNT: begin
          if (!en) begin
            state <= IDLE;
          end else if (count > 32'd1) begin
            count <= count - 32'd1;
          end else begin
            // 0 and 1 both expire here, so the counter can never underflow
            count   <= '0;
            irqFlag <= 1'b1;
            state   <= INT;
          end
        end
        INT: begin
          if (mode == MODE_RELOAD) irqFlag <= 1'b0;
          else                     en      <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // Placed last so a software CTRL write overrides any same-edge FSM update
      if (ctrlWe) begin
        en      <= bus.wd[CTRL_EN];
        mode    <= bus.wd[CTRL_MODE_HI:CTRL_MODE_LO];
        im      <= bus.wd[CTRL_IM];
        irqFlag <= 1'b0;
      end
    end
  end

  always_comb begin
    rdMux = '0;
    case (offset)
      OFF_CTRL:   rdMux = {{(WORD_W-4){1'b0}}, im, mode, en};
      OFF_PRESET: rdMux = preset;
      OFF_COUNT:  rdMux = count;
      default:    rdMux = '0;
    endcase
  end

  assign bus.rd  = rdMux;
  assign bus.irq = irqFlag & im;

endmodule
